// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and constants for the memory responder
//
// Purpose : loader FSM state encoding, instruction word-index width and the
//           NOP word returned whenever no valid fetch/load data exists.
// Ports   : none (package).

package mem_responder_pkg;

    // Program-download sequencer states.
    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } loader_state_t;

    // Word index carried by pc[7:2] / address[7:2].
    localparam int WORD_IDX_W = 6;

    // Value driven on instruction/readData when nothing valid is addressed.
    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/mem_responder_data.sv
// rtl/mem_responder_data.sv - data RAM with combinational read and synchronous write
//
// Purpose : processor data memory. Read is a pure combinational lookup, so a
//           write and a read of the same word in one cycle see the old value
//           until the clock edge commits the write.
// Ports   : clk   - system clock
//           we    - write enable (already qualified by the caller)
//           addr  - word index shared by the read and write paths
//           wdata - write data
//           rdata - combinational read data

module data_ram
    import mem_responder_pkg::*;
#(
    parameter int WORDS = 64
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORD_IDX_W-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    // No reset on the array: contents survive a responder reset.
    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - instruction/data memory responder with program loader
//
// Purpose : holds the processor's instruction store, downloads a program into
//           it through a valid/ready loader port, then releases the processor
//           (run) and serves fetches, loads and stores, flagging range and
//           alignment faults.
// Ports   : clk, rst                      - clock, async active-high reset
//           pc, instruction               - fetch byte address / fetched word
//           address, writeData, WR        - data access address, store data, store strobe
//           MemtoReg                      - load in progress (alignment check only)
//           readData                      - combinational load data
//           load_start                    - begin (or restart) a download
//           load_valid, load_last,
//           load_data, load_ready         - loader word handshake
//           run                           - processor may execute
//           err_range, err_align          - sticky fault flags
//           load_count                    - words stored by the current/last download

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pc,
    output logic [31:0] instruction,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        WR,
    input  logic        MemtoReg,
    output logic [31:0] readData,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic        load_last,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        run,
    output logic        err_range,
    output logic        err_align,
    output logic [7:0]  load_count
);

    localparam logic [8:0]  IMEM_BYTES = 9'(IMEM_WORDS * 4);
    localparam logic [8:0]  IMEM_LIMIT = 9'(IMEM_WORDS);
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

    loader_state_t state;
    loader_state_t state_next;

    logic [31:0] imem [IMEM_WORDS];

    logic        accept;
    logic        imem_full;
    logic        imem_we;
    logic        pc_ok;
    logic        addr_ok;
    logic        misaligned;
    logic        dmem_we;
    logic [31:0] ram_rdata;

    // ------------------------------------------------------------------
    // Loader FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            LD_IDLE: begin
                if (load_start) begin
                    state_next = LD_LOAD;
                end
            end
            LD_LOAD: begin
                // load_start here restarts the download and stays in LOAD.
                if (load_start) begin
                    state_next = LD_LOAD;
                end else if (accept && load_last) begin
                    state_next = LD_DONE;
                end
            end
            LD_DONE: begin
                if (load_start) begin
                    state_next = LD_LOAD;
                end
            end
            default: begin
                state_next = LD_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Loader FSM: outputs
    // ------------------------------------------------------------------
    // Ready drops during a restart pulse so the word presented in that
    // cycle is visibly not taken.
    always_comb begin
        load_ready = 1'b0;
        run        = 1'b0;
        case (state)
            LD_LOAD: load_ready = ~load_start;
            LD_DONE: run        = 1'b1;
            default: begin
                load_ready = 1'b0;
                run        = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Qualifiers
    // ------------------------------------------------------------------
    assign accept     = load_valid & load_ready;
    assign imem_full  = ({1'b0, load_count} >= IMEM_LIMIT);
    // Words past the end of the store still complete the handshake but
    // are discarded.
    assign imem_we    = accept & ~imem_full;
    assign pc_ok      = ({1'b0, pc} < IMEM_BYTES);
    assign addr_ok    = (address < DMEM_BYTES);
    assign misaligned = (address[1:0] != 2'b00);
    assign dmem_we    = run & WR & addr_ok;

    // ------------------------------------------------------------------
    // Download word counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_count <= 8'd0;
        end else if (load_start) begin
            load_count <= 8'd0;
        end else if (imem_we) begin
            load_count <= load_count + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Instruction store: no reset, so a reset mid-download keeps the
    // words already written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[load_count[WORD_IDX_W-1:0]] <= load_data;
        end
    end

    always_comb begin
        instruction = NOP;
        if (run && pc_ok) begin
            instruction = imem[pc[WORD_IDX_W+1:2]];
        end
    end

    // ------------------------------------------------------------------
    // Data memory; misaligned accesses simply drop address[1:0].
    // ------------------------------------------------------------------
    data_ram #(
        .WORDS (DMEM_WORDS)
    ) u_data_ram (
        .clk   (clk),
        .we    (dmem_we),
        .addr  (address[WORD_IDX_W+1:2]),
        .wdata (writeData),
        .rdata (ram_rdata)
    );

    assign readData = addr_ok ? ram_rdata : NOP;

    // ------------------------------------------------------------------
    // Sticky fault flags. Everything except the loader overflow is only
    // considered while the processor is running, so stray strobes before
    // release never raise a flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_range <= 1'b0;
            err_align <= 1'b0;
        end else if (load_start) begin
            err_range <= 1'b0;
            err_align <= 1'b0;
        end else begin
            if ((accept && imem_full) || (run && WR && !addr_ok) || (run && !pc_ok)) begin
                err_range <= 1'b1;
            end
            if (run && (WR || MemtoReg) && misaligned) begin
                err_align <= 1'b1;
            end
        end
    end

endmodule
